// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, instruction classes,
// opcode/funct values and PC mux selects.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT_BR = 3'd4,
        ST_JUMP    = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_BRANCH = 3'd1,
        CLS_J      = 3'd2,
        CLS_JAL    = 3'd3,
        CLS_JR     = 3'd4,
        CLS_HALT   = 3'd5
    } ins_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_BREAK = 6'h0D;

    localparam logic [1:0] PCSEL_BRANCH = 2'b00;
    localparam logic [1:0] PCSEL_JUMP   = 2'b01;
    localparam logic [1:0] PCSEL_REG    = 2'b10;

endpackage

// File: rtl/fetch_sequencer_ins_classifier.sv
// Combinational IR -> instruction class decode; shared with the execute-side decoder.
module ins_classifier
    import fetch_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [2:0]  o_class
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_ir;

    assign w_op        = i_ir[31:26];
    assign w_funct     = i_ir[5:0];
    assign w_unused_ir = ^i_ir[25:6];

    always_comb begin
        o_class = CLS_ALU;
        if (w_op == OP_RTYPE && w_funct == FN_JR) begin
            o_class = CLS_JR;
        end else if (w_op == OP_RTYPE && w_funct == FN_BREAK) begin
            o_class = CLS_HALT;
        end else if (w_op == OP_J) begin
            o_class = CLS_J;
        end else if (w_op == OP_JAL) begin
            o_class = CLS_JAL;
        end else if (w_op == OP_BEQ || w_op == OP_BNE) begin
            o_class = CLS_BRANCH;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue control FSM in front of the Instruction Unit: drives memory, PC and IR
// controls, issues instructions over valid/ready, steers PC, counts retirements.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      IR_in,
    input  logic             ins_ready,
    input  logic             br_valid,
    input  logic             br_taken,
    output logic             im_cs,
    output logic             im_rd,
    output logic             im_wr,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic [1:0]       pc_sel,
    output logic             ins_valid,
    output logic [2:0]       ins_class,
    output logic             halted,
    output logic             stall_err,
    output logic [CNT_W-1:0] icount
);

    state_t           r_state;
    state_t           w_next;
    ins_class_t       r_class;
    logic [CNT_W-1:0] r_icount;
    logic [15:0]      r_wd;
    logic             r_stall_err;
    logic [2:0]       w_class;
    logic             w_retire;
    logic             w_stalling;
    logic             w_wd_entry;

    ins_classifier u_classifier (
        .i_ir    (IR_in),
        .o_class (w_class)
    );

    always_comb begin
        w_next     = r_state;
        im_cs      = 1'b0;
        im_rd      = 1'b0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        pc_sel     = PCSEL_BRANCH;
        ins_valid  = 1'b0;
        halted     = 1'b0;
        w_retire   = 1'b0;
        w_stalling = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                im_cs  = 1'b1;
                im_rd  = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_class)
                    CLS_HALT: w_next = ST_HALT;
                    CLS_J:    w_next = ST_JUMP;
                    default:  w_next = ST_ISSUE;
                endcase
            end
            ST_ISSUE: begin
                ins_valid = 1'b1;
                if (ins_ready) begin
                    case (r_class)
                        CLS_BRANCH, CLS_JR: w_next = ST_WAIT_BR;
                        CLS_JAL:            w_next = ST_JUMP;
                        default: begin
                            w_retire = 1'b1;
                            w_next   = run ? ST_FETCH : ST_IDLE;
                        end
                    endcase
                end else begin
                    w_stalling = 1'b1;
                end
            end
            ST_WAIT_BR: begin
                // Only this state drives PC from an input (Mealy on br_valid/br_taken).
                if (br_valid) begin
                    if (r_class == CLS_JR) begin
                        pc_ld  = 1'b1;
                        pc_sel = PCSEL_REG;
                    end else if (br_taken) begin
                        pc_ld  = 1'b1;
                        pc_sel = PCSEL_BRANCH;
                    end
                    w_retire = 1'b1;
                    w_next   = run ? ST_FETCH : ST_IDLE;
                end else begin
                    w_stalling = 1'b1;
                end
            end
            ST_JUMP: begin
                pc_ld    = 1'b1;
                pc_sel   = PCSEL_JUMP;
                w_retire = 1'b1;
                w_next   = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_wd_entry = (w_next != r_state) &&
                        (w_next == ST_ISSUE || w_next == ST_WAIT_BR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_class     <= CLS_ALU;
            r_icount    <= '0;
            r_wd        <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) r_class <= ins_class_t'(w_class);
            if (w_retire) r_icount <= r_icount + CNT_W'(1);
            // Counter saturates so a long stall cannot wrap back below the limit.
            if (w_wd_entry) begin
                r_wd <= '0;
            end else if (w_stalling && r_wd != '1) begin
                r_wd <= r_wd + 16'd1;
            end
            if (w_stalling && ({1'b0, r_wd} + 17'd1 == 17'(STALL_LIMIT))) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign im_wr     = 1'b0;
    assign ins_class = r_class;
    assign stall_err = r_stall_err;
    assign icount    = r_icount;

endmodule
